// File: rtl/front_panel_scan_pkg.sv
// Shared types and constants for the front-panel LED matrix scanner.
package front_panel_pkg;

    localparam int NUM_ROWS = 5;
    localparam int COLS     = 8;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ROW_ADDR_LO = 3'd0,
        ROW_ADDR_HI = 3'd1,
        ROW_DATA    = 3'd2,
        ROW_STATUS  = 3'd3,
        ROW_CTRL    = 3'd4
    } row_e;

    function automatic logic [NUM_ROWS-1:0] row_onehot(input row_e row);
        logic [NUM_ROWS-1:0] v;
        case (row)
            ROW_ADDR_LO: v = 5'b00001;
            ROW_ADDR_HI: v = 5'b00010;
            ROW_DATA:    v = 5'b00100;
            ROW_STATUS:  v = 5'b01000;
            ROW_CTRL:    v = 5'b10000;
            default:     v = 5'b00000;
        endcase
        return v;
    endfunction

    function automatic row_e next_row(input row_e row);
        row_e v;
        case (row)
            ROW_ADDR_LO: v = ROW_ADDR_HI;
            ROW_ADDR_HI: v = ROW_DATA;
            ROW_DATA:    v = ROW_STATUS;
            ROW_STATUS:  v = ROW_CTRL;
            ROW_CTRL:    v = ROW_ADDR_LO;
            default:     v = ROW_ADDR_LO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/front_panel_scan_if.sv
// Monitor-bus inputs and LED matrix outputs of the front-panel scanner.
interface front_panel_scan_if;

    logic [15:0]                          mon_addr;
    logic [7:0]                           mon_data;
    logic [7:0]                           mon_status;
    logic [7:0]                           ctrl_leds;
    logic [3:0]                           brightness;
    logic [front_panel_pkg::NUM_ROWS-1:0] led_row;
    logic [front_panel_pkg::COLS-1:0]     led_col;
    logic                                 frame_start;

    modport master (
        output mon_addr, mon_data, mon_status, ctrl_leds, brightness,
        input  led_row, led_col, frame_start
    );

    modport slave (
        input  mon_addr, mon_data, mon_status, ctrl_leds, brightness,
        output led_row, led_col, frame_start
    );

endinterface

// File: rtl/front_panel_scan_pwm_gate.sv
// Brightness gate: columns are enabled while the dwell count is below the
// on-time derived from the 4-bit brightness level.
module pwm_gate #(
    parameter  int DWELL_CYCLES = 64,
    localparam int CW           = $clog2(DWELL_CYCLES) + 1
) (
    input  logic [CW-1:0] i_dwell_cnt,
    input  logic [3:0]    i_brightness,
    output logic          o_col_enable
);

    localparam int STEP = DWELL_CYCLES / 16;

    logic [4:0]    w_level;
    logic [CW-1:0] w_on_time;

    // on_time = (level+1) * DWELL/16, never exceeds DWELL so CW bits suffice
    always_comb begin
        w_level   = {1'b0, i_brightness} + 5'd1;
        w_on_time = CW'(w_level) * CW'(STEP);
        if (i_dwell_cnt < w_on_time) begin
            o_col_enable = 1'b1;
        end else begin
            o_col_enable = 1'b0;
        end
    end

endmodule

// File: rtl/front_panel_scan.sv
// Time-multiplexed 5x8 front-panel LED driver: per-frame snapshot of the monitor
// buses, row scan with dead-time blanking and PWM brightness.
module front_panel_scan
    import front_panel_pkg::*;
#(
    parameter int DWELL_CYCLES = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    front_panel_scan_if.slave bus
);

    localparam int CW = $clog2(DWELL_CYCLES) + 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    state_e              r_state;
    row_e                r_row;
    logic [BW-1:0]       r_blank_cnt;
    logic [CW-1:0]       r_dwell_cnt;
    logic [15:0]         r_snap_addr;
    logic [7:0]          r_snap_data;
    logic [7:0]          r_snap_status;
    logic [7:0]          r_snap_ctrl;
    logic [3:0]          r_snap_bright;
    logic [NUM_ROWS-1:0] r_led_row;
    logic [COLS-1:0]     r_led_col;
    logic                r_frame_start;

    logic [COLS-1:0]     w_row_byte;
    logic                w_col_enable;
    logic                w_snap_take;

    pwm_gate #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_pwm_gate (
        .i_dwell_cnt  (r_dwell_cnt),
        .i_brightness (r_snap_bright),
        .o_col_enable (w_col_enable)
    );

    assign w_snap_take = (r_state == BLANK) && (r_row == ROW_ADDR_LO) &&
                         (r_blank_cnt == {BW{1'b0}});

    // Select the snapshot byte shown on the current row
    always_comb begin
        w_row_byte = 8'h00;
        case (r_row)
            ROW_ADDR_LO: w_row_byte = r_snap_addr[7:0];
            ROW_ADDR_HI: w_row_byte = r_snap_addr[15:8];
            ROW_DATA:    w_row_byte = r_snap_data;
            ROW_STATUS:  w_row_byte = r_snap_status;
            ROW_CTRL:    w_row_byte = r_snap_ctrl;
            default:     w_row_byte = 8'h00;
        endcase
    end

    // Scan FSM with snapshot capture and registered pin outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BLANK;
            r_row         <= ROW_ADDR_LO;
            r_blank_cnt   <= {BW{1'b0}};
            r_dwell_cnt   <= {CW{1'b0}};
            r_snap_addr   <= 16'h0000;
            r_snap_data   <= 8'h00;
            r_snap_status <= 8'h00;
            r_snap_ctrl   <= 8'h00;
            r_snap_bright <= 4'h0;
            r_led_row     <= 5'b00000;
            r_led_col     <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap_take;
            if (w_snap_take) begin
                r_snap_addr   <= bus.mon_addr;
                r_snap_data   <= bus.mon_data;
                r_snap_status <= bus.mon_status;
                r_snap_ctrl   <= bus.ctrl_leds;
                r_snap_bright <= bus.brightness;
            end
            case (r_state)
                BLANK: begin
                    r_led_row <= 5'b00000;
                    r_led_col <= 8'hFF;
                    if (r_blank_cnt == BW'(BLANK_CYCLES - 1)) begin
                        r_blank_cnt <= {BW{1'b0}};
                        r_state     <= DRIVE;
                    end else begin
                        r_blank_cnt <= r_blank_cnt + BW'(1);
                    end
                end
                DRIVE: begin
                    // Row stays enabled through PWM-off cycles; only columns are gated
                    r_led_row <= row_onehot(r_row);
                    r_led_col <= w_col_enable ? ~w_row_byte : 8'hFF;
                    if (r_dwell_cnt == CW'(DWELL_CYCLES - 1)) begin
                        r_dwell_cnt <= {CW{1'b0}};
                        r_state     <= BLANK;
                        r_row       <= next_row(r_row);
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state   <= BLANK;
                    r_led_row <= 5'b00000;
                    r_led_col <= 8'hFF;
                end
            endcase
        end
    end

    assign bus.led_row     = r_led_row;
    assign bus.led_col     = r_led_col;
    assign bus.frame_start = r_frame_start;

endmodule
